object_fetcher: RTL and testbench

Per-frame reader for the triangle object buffer. On each frame start it rewinds the buffer, walks every stored `object_t` in order, and computes a screen-clamped bounding box for each. It then hands object and box to the rasterizer setup stage over a valid/ready handshake. It is the sole driver of the buffer's `next_frame` and `read_b` inputs, and it signals end of frame.

---
 rtl/common_pkg.sv | 56 +++++
 rtl/object_fetcher_bbox_calc.sv | 48 ++++
 rtl/object_fetcher.sv | 132 +++++++++++++
 tb/tb_object_fetcher.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common (package)
// Description : Shared geometry and control types for the triangle pipeline.
//               point_t / object_t describe a stored triangle; bbox_t is the
//               screen-clamped bounding box handed to rasterizer setup;
//               fetch_state_t is the object_fetcher walk state.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

   localparam int COORD_W = 16;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } point_t;

   typedef struct packed {
      point_t a;
      point_t b;
      point_t c;
   } object_t;

   typedef struct packed {
      coord_t min_x;
      coord_t min_y;
      coord_t max_x;
      coord_t max_y;
   } bbox_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REWIND  = 3'd1,
      S_CHECK   = 3'd2,
      S_SETUP   = 3'd3,
      S_PRESENT = 3'd4,
      S_DONE    = 3'd5
   } fetch_state_t;

   function automatic coord_t min3(input coord_t p, input coord_t q, input coord_t r);
      coord_t m;
      m = (p < q) ? p : q;
      return (m < r) ? m : r;
   endfunction

   function automatic coord_t max3(input coord_t p, input coord_t q, input coord_t r);
      coord_t m;
      m = (p > q) ? p : q;
      return (m > r) ? m : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/object_fetcher_bbox_calc.sv
`default_nettype none
// ============================================================================
// Module      : bbox_calc
// Description : Combinational bounding box of one triangle. Max corners are
//               clamped to the last visible pixel; the triangle is culled
//               when its min corner lies entirely off-screen.
// Ports       : obj  in  object_t  triangle to bound
//               box  out bbox_t    clamped bounding box
//               cull out 1         triangle is fully off-screen
// Revision    : 1.0 - initial release
// ============================================================================
module bbox_calc
   import common::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  object_t obj,
   output bbox_t   box,
   output logic    cull
);

   // Screen limits at coordinate width so every compare is same-width.
   localparam coord_t c_x_last = coord_t'(H_RES - 1);
   localparam coord_t c_y_last = coord_t'(V_RES - 1);

   coord_t w_min_x;
   coord_t w_min_y;
   coord_t w_max_x;
   coord_t w_max_y;

   assign w_min_x = min3(obj.a.x, obj.b.x, obj.c.x);
   assign w_min_y = min3(obj.a.y, obj.b.y, obj.c.y);
   assign w_max_x = max3(obj.a.x, obj.b.x, obj.c.x);
   assign w_max_y = max3(obj.a.y, obj.b.y, obj.c.y);

   // Coordinates are unsigned, so only the upper edge needs clamping.
   assign box = '{
      min_x: w_min_x,
      min_y: w_min_y,
      max_x: (w_max_x > c_x_last) ? c_x_last : w_max_x,
      max_y: (w_max_y > c_y_last) ? c_y_last : w_max_y
   };

   assign cull = (w_min_x > c_x_last) || (w_min_y > c_y_last);

endmodule
`default_nettype wire

// File: rtl/object_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : object_fetcher
// Description : Per-frame walker over the triangle object buffer. Rewinds the
//               buffer on frame_start, reads each object, computes a clamped
//               bounding box and presents object+box over valid/ready.
// Ports       : clock, reset (sync, active-high)
//               frame_start in  - start one frame (ignored + overrun if busy)
//               next_frame  out - buffer rewind strobe (registered)
//               read_b      out - buffer advance strobe (registered)
//               data_b      in  - object at buffer cursor
//               read_end    in  - buffer cursor at end
//               out_valid/out_ready/out_obj/out_box - downstream handshake
//               frame_done  out - one-cycle end-of-frame pulse
//               busy        out - not idle
//               dropped     out - culled objects this frame (saturating)
//               overrun     out - sticky frame_start-while-busy flag
// Revision    : 1.0 - initial release
// ============================================================================
module object_fetcher
   import common::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_start,
   output logic       next_frame,
   output logic       read_b,
   input  object_t    data_b,
   input  logic       read_end,
   output logic       out_valid,
   input  logic       out_ready,
   output object_t    out_obj,
   output bbox_t      out_box,
   output logic       frame_done,
   output logic       busy,
   output logic [7:0] dropped,
   output logic       overrun
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;

   logic         r_next_frame;
   logic         r_read_b;
   object_t      r_obj;
   bbox_t        r_box;
   logic [7:0]   r_dropped;
   logic         r_overrun;

   bbox_t        w_box;
   logic         w_cull;
   logic         w_take;

   bbox_calc #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_bbox_calc (
      .obj  (r_obj),
      .box  (w_box),
      .cull (w_cull)
   );

   // An object is consumed from the buffer when CHECK finds it non-empty.
   assign w_take = (r_state == S_CHECK) && !read_end;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (frame_start) w_next_state = S_REWIND;
         S_REWIND:  w_next_state = S_CHECK;
         S_CHECK:   w_next_state = read_end ? S_DONE : S_SETUP;
         S_SETUP:   w_next_state = w_cull ? S_CHECK : S_PRESENT;
         S_PRESENT: if (out_ready) w_next_state = S_CHECK;
         S_DONE:    w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Strobes are registered: each is high in the cycle after its decision,
   // so the buffer cursor moves on the following edge, and the next CHECK
   // is always at least two edges later.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_next_frame <= 1'b0;
         r_read_b     <= 1'b0;
         r_obj        <= '0;
         r_box        <= '0;
         r_dropped    <= 8'd0;
         r_overrun    <= 1'b0;
      end else begin
         r_next_frame <= (r_state == S_IDLE) && frame_start;
         r_read_b     <= w_take;
         if (w_take) begin
            r_obj <= data_b;
         end
         if (r_state == S_SETUP) begin
            r_box <= w_box;
         end
         if ((r_state == S_IDLE) && frame_start) begin
            r_dropped <= 8'd0;
         end else if ((r_state == S_SETUP) && w_cull && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
         end
         if ((r_state != S_IDLE) && frame_start) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign next_frame = r_next_frame;
   assign read_b     = r_read_b;
   assign out_obj    = r_obj;
   assign out_box    = r_box;
   assign out_valid  = (r_state == S_PRESENT);
   assign frame_done = (r_state == S_DONE);
   assign busy       = (r_state != S_IDLE);
   assign dropped    = r_dropped;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_object_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_object_fetcher
// Description : Self-checking bench for object_fetcher. Holds a behavioural
//               object buffer and a reference bounding-box model; each test
//               task drives one scenario and checks its own results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_fetcher;
   import common::*;

   localparam int H_RES = 640;
   localparam int V_RES = 480;
   localparam int MEM_N = 300;

   logic       clock = 1'b0;
   logic       reset;
   logic       frame_start;
   logic       next_frame;
   logic       read_b;
   object_t    data_b;
   logic       read_end;
   logic       out_valid;
   logic       out_ready;
   object_t    out_obj;
   bbox_t      out_box;
   logic       frame_done;
   logic       busy;
   logic [7:0] dropped;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   object_fetcher #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .frame_start (frame_start),
      .next_frame  (next_frame),
      .read_b      (read_b),
      .data_b      (data_b),
      .read_end    (read_end),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_obj     (out_obj),
      .out_box     (out_box),
      .frame_done  (frame_done),
      .busy        (busy),
      .dropped     (dropped),
      .overrun     (overrun)
   );

   // ---------------- object buffer model ----------------
   object_t mem [0:MEM_N-1];
   int      count  = 0;
   int      cursor = 0;

   always @(posedge clock) begin
      if (next_frame) cursor <= 0;
      else if (read_b) cursor <= cursor + 1;
   end

   assign data_b   = (cursor < MEM_N) ? mem[cursor] : '0;
   assign read_end = (cursor == count);

   // ---------------- monitor (samples on falling edge) ----------------
   int      cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bbox_t   hs_box [$];
   object_t hs_obj [$];
   int      hs_cyc [$];
   int      first_valid_cyc, valid_cycles, done_count, done_cyc;
   int      readb_count, nf_count, overlap, unstable, stall_readb;
   bit      prev_stall;
   object_t prev_obj;
   bbox_t   prev_box;
   int      start_cyc;
   bit      timed_out;

   always @(negedge clock) begin
      if (prev_stall && (!out_valid || out_obj !== prev_obj || out_box !== prev_box))
         unstable++;
      if (out_valid && !out_ready && read_b) stall_readb++;
      if (out_valid) begin
         valid_cycles++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
         hs_box.push_back(out_box);
         hs_obj.push_back(out_obj);
         hs_cyc.push_back(cyc);
      end
      if (frame_done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (read_b) readb_count++;
      if (next_frame) nf_count++;
      if (read_b && next_frame) overlap++;
      prev_stall = out_valid && !out_ready;
      prev_obj   = out_obj;
      prev_box   = out_box;
   end

   task automatic clear_mon();
      hs_box.delete();
      hs_obj.delete();
      hs_cyc.delete();
      first_valid_cyc = -1;
      valid_cycles = 0;
      done_count = 0;
      done_cyc = -1;
      readb_count = 0;
      nf_count = 0;
      overlap = 0;
      unstable = 0;
      stall_readb = 0;
      prev_stall = 1'b0;
   endtask

   // ---------------- reference model ----------------
   function automatic object_t mk_obj(input int ax, input int ay, input int bx,
                                      input int by, input int cx, input int cy);
      object_t o;
      o.a.x = coord_t'(ax); o.a.y = coord_t'(ay);
      o.b.x = coord_t'(bx); o.b.y = coord_t'(by);
      o.c.x = coord_t'(cx); o.c.y = coord_t'(cy);
      return o;
   endfunction

   function automatic bbox_t mk_box(input int x0, input int y0, input int x1, input int y1);
      bbox_t b;
      b.min_x = coord_t'(x0); b.min_y = coord_t'(y0);
      b.max_x = coord_t'(x1); b.max_y = coord_t'(y1);
      return b;
   endfunction

   // Box of a triangle from its vertex list; off-screen triangles are culled.
   function automatic bit ref_box(input object_t o, output bbox_t b);
      int xs [3];
      int ys [3];
      int lo_x, hi_x, lo_y, hi_y;
      xs[0] = int'(o.a.x); xs[1] = int'(o.b.x); xs[2] = int'(o.c.x);
      ys[0] = int'(o.a.y); ys[1] = int'(o.b.y); ys[2] = int'(o.c.y);
      lo_x = xs[0]; hi_x = xs[0]; lo_y = ys[0]; hi_y = ys[0];
      for (int i = 1; i < 3; i++) begin
         if (xs[i] < lo_x) lo_x = xs[i];
         if (xs[i] > hi_x) hi_x = xs[i];
         if (ys[i] < lo_y) lo_y = ys[i];
         if (ys[i] > hi_y) hi_y = ys[i];
      end
      if (hi_x > H_RES - 1) hi_x = H_RES - 1;
      if (hi_y > V_RES - 1) hi_y = V_RES - 1;
      b = mk_box(lo_x, lo_y, hi_x, hi_y);
      return (lo_x > H_RES - 1) || (lo_y > V_RES - 1);
   endfunction

   task automatic load_basic();
      mem[0] = mk_obj(10, 10, 100, 15, 50, 75);
      mem[1] = mk_obj(1, 1, 10, 1, 1, 10);
      count  = 2;
   endtask

   // ---------------- frame runner (stimulus only) ----------------
   task automatic run_frame(input int stall_n, input bit rnd_ready, input bit overrun_poke);
      int stalls_left;
      int budget;
      bit poked;
      clear_mon();
      stalls_left = stall_n;
      poked = 1'b0;
      timed_out = 1'b0;
      @(posedge clock); #1;
      frame_start = 1'b1;
      out_ready = 1'b1;
      start_cyc = cyc;
      @(posedge clock); #1;
      frame_start = 1'b0;
      budget = 0;
      while (done_count == 0 && budget < 5000) begin
         if (out_valid && stalls_left > 0) begin
            out_ready = 1'b0;
            stalls_left--;
         end else begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (overrun_poke && out_valid && !poked) begin
            frame_start = 1'b1;
            poked = 1'b1;
         end else begin
            frame_start = 1'b0;
         end
         @(posedge clock); #1;
         budget++;
      end
      frame_start = 1'b0;
      out_ready = 1'b1;
      if (done_count == 0) timed_out = 1'b1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      frame_start = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({next_frame, read_b, out_valid, frame_done, busy, overrun, dropped, out_obj, out_box} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {next_frame, read_b, out_valid, frame_done, busy, overrun, dropped, out_obj, out_box});
      end
      reset = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy got %b want 0", busy);
      end
   endtask

   task automatic test_basic();
      load_basic();
      run_frame(0, 1'b0, 1'b0);
      checks++;
      if (timed_out) begin errors++; $display("FAIL basic_timeout got none want frame_done"); end
      checks++;
      if (hs_box.size() != 2) begin
         errors++;
         $display("FAIL basic_hs_count got %0d want 2", hs_box.size());
      end else begin
         checks++;
         if (hs_box[0] !== mk_box(10, 10, 100, 75)) begin
            errors++; $display("FAIL basic_box0 got %h want %h", hs_box[0], mk_box(10, 10, 100, 75));
         end
         checks++;
         if (hs_box[1] !== mk_box(1, 1, 10, 10)) begin
            errors++; $display("FAIL basic_box1 got %h want %h", hs_box[1], mk_box(1, 1, 10, 10));
         end
         checks++;
         if (hs_obj[0] !== mem[0] || hs_obj[1] !== mem[1]) begin
            errors++; $display("FAIL basic_objs got %h %h want %h %h", hs_obj[0], hs_obj[1], mem[0], mem[1]);
         end
         checks++;
         if (hs_cyc[1] - hs_cyc[0] != 3) begin
            errors++; $display("FAIL basic_throughput got %0d want 3", hs_cyc[1] - hs_cyc[0]);
         end
         // Last handshake -> CHECK sees read_end -> DONE.
         checks++;
         if (done_cyc - hs_cyc[1] != 2) begin
            errors++; $display("FAIL basic_done_after_hs got %0d want 2", done_cyc - hs_cyc[1]);
         end
      end
      checks++;
      if (first_valid_cyc - start_cyc != 4) begin
         errors++; $display("FAIL basic_latency got %0d want 4", first_valid_cyc - start_cyc);
      end
      checks++;
      if (readb_count != 2 || nf_count != 1 || overlap != 0) begin
         errors++;
         $display("FAIL basic_strobes got read_b=%0d next_frame=%0d overlap=%0d want 2 1 0",
                  readb_count, nf_count, overlap);
      end
      checks++;
      if (dropped !== 8'd0 || done_count != 1) begin
         errors++; $display("FAIL basic_dropped_done got %0d/%0d want 0/1", dropped, done_count);
      end
   endtask

   task automatic test_stall();
      load_basic();
      run_frame(5, 1'b0, 1'b0);
      checks++;
      if (unstable != 0 || stall_readb != 0) begin
         errors++; $display("FAIL stall_hold got unstable=%0d read_b=%0d want 0 0", unstable, stall_readb);
      end
      checks++;
      if (hs_box.size() != 2) begin
         errors++; $display("FAIL stall_hs_count got %0d want 2", hs_box.size());
      end else begin
         checks++;
         if (hs_box[0] !== mk_box(10, 10, 100, 75) || hs_box[1] !== mk_box(1, 1, 10, 10)) begin
            errors++; $display("FAIL stall_order got %h %h", hs_box[0], hs_box[1]);
         end
         checks++;
         if (hs_cyc[0] - first_valid_cyc != 5) begin
            errors++; $display("FAIL stall_len got %0d want 5", hs_cyc[0] - first_valid_cyc);
         end
      end
   endtask

   task automatic test_cull();
      mem[0] = mk_obj(700, 10, 800, 20, 750, 30);
      count = 1;
      run_frame(0, 1'b0, 1'b0);
      checks++;
      if (dropped !== 8'd1 || valid_cycles != 0 || done_count != 1) begin
         errors++;
         $display("FAIL cull got dropped=%0d valid=%0d done=%0d want 1 0 1", dropped, valid_cycles, done_count);
      end
   endtask

   task automatic test_clamp();
      mem[0] = mk_obj(600, 400, 900, 600, 620, 450);
      count = 1;
      run_frame(0, 1'b0, 1'b0);
      checks++;
      if (hs_box.size() != 1) begin
         errors++; $display("FAIL clamp_hs_count got %0d want 1", hs_box.size());
      end else if (hs_box[0] !== mk_box(600, 400, 639, 479)) begin
         errors++; $display("FAIL clamp_box got %h want %h", hs_box[0], mk_box(600, 400, 639, 479));
      end
      checks++;
      if (dropped !== 8'd0) begin
         errors++; $display("FAIL clamp_dropped_cleared got %0d want 0", dropped);
      end
   endtask

   task automatic test_empty();
      count = 0;
      run_frame(0, 1'b0, 1'b0);
      checks++;
      if (done_cyc - start_cyc != 3 || readb_count != 0 || valid_cycles != 0) begin
         errors++;
         $display("FAIL empty got done_lat=%0d read_b=%0d valid=%0d want 3 0 0",
                  done_cyc - start_cyc, readb_count, valid_cycles);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) mem[i] = mk_obj(700, 10, 800, 20, 750, 30);
      count = 260;
      run_frame(0, 1'b0, 1'b0);
      checks++;
      if (dropped !== 8'd255 || timed_out) begin
         errors++; $display("FAIL saturate got dropped=%0d timeout=%0b want 255 0", dropped, timed_out);
      end
   endtask

   task automatic test_overrun();
      load_basic();
      run_frame(0, 1'b0, 1'b1);
      checks++;
      if (overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_flag got %b want 1", overrun);
      end
      checks++;
      if (hs_box.size() != 2 || done_count != 1 || nf_count != 1) begin
         errors++;
         $display("FAIL overrun_frame got hs=%0d done=%0d next_frame=%0d want 2 1 1",
                  hs_box.size(), done_count, nf_count);
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      load_basic();
      clear_mon();
      out_ready = 1'b0;
      @(posedge clock); #1;
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(posedge clock); #1;
         waited++;
      end
      checks++;
      if (!out_valid) begin
         errors++; $display("FAIL resetmid_no_valid got 0 want 1");
      end
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if ({next_frame, read_b, out_valid, frame_done, busy, overrun, dropped, out_obj, out_box} !== '0) begin
         errors++;
         $display("FAIL resetmid_outputs got %h want 0",
                  {next_frame, read_b, out_valid, frame_done, busy, overrun, dropped, out_obj, out_box});
      end
      reset = 1'b0;
      out_ready = 1'b1;
      clear_mon();
      repeat (6) @(posedge clock);
      #1;
      checks++;
      if (done_count != 0 || readb_count != 0 || valid_cycles != 0) begin
         errors++;
         $display("FAIL resetmid_quiet got done=%0d read_b=%0d valid=%0d want 0 0 0",
                  done_count, readb_count, valid_cycles);
      end
      run_frame(0, 1'b0, 1'b0);
      checks++;
      if (hs_box.size() != 2) begin
         errors++; $display("FAIL resetmid_replay_count got %0d want 2", hs_box.size());
      end else if (hs_obj[0] !== mem[0] || hs_box[0] !== mk_box(10, 10, 100, 75)) begin
         errors++; $display("FAIL resetmid_replay got %h want %h", hs_obj[0], mem[0]);
      end
   endtask

   function automatic int rnd_coord();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 65535));
      return int'($urandom_range(0, 900));
   endfunction

   task automatic test_random();
      bbox_t   exp_box [$];
      object_t exp_obj [$];
      bbox_t   b;
      int      culls;
      int      exp_drop;
      for (int f = 0; f < 25; f++) begin
         count = int'($urandom_range(0, 8));
         for (int i = 0; i < count; i++)
            mem[i] = mk_obj(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
         exp_box.delete();
         exp_obj.delete();
         culls = 0;
         for (int i = 0; i < count; i++) begin
            if (ref_box(mem[i], b)) culls++;
            else begin
               exp_box.push_back(b);
               exp_obj.push_back(mem[i]);
            end
         end
         exp_drop = (culls > 255) ? 255 : culls;
         run_frame(0, 1'b1, 1'b0);
         checks++;
         if (hs_box.size() != exp_box.size() || timed_out) begin
            errors++;
            $display("FAIL rand_count frame %0d got %0d want %0d (timeout %0b)",
                     f, hs_box.size(), exp_box.size(), timed_out);
         end else begin
            for (int i = 0; i < exp_box.size(); i++) begin
               checks++;
               if (hs_box[i] !== exp_box[i] || hs_obj[i] !== exp_obj[i]) begin
                  errors++;
                  $display("FAIL rand_item frame %0d idx %0d got %h/%h want %h/%h",
                           f, i, hs_box[i], hs_obj[i], exp_box[i], exp_obj[i]);
               end
            end
         end
         checks++;
         if (int'(dropped) != exp_drop || unstable != 0 || overlap != 0 || readb_count != count) begin
            errors++;
            $display("FAIL rand_status frame %0d got drop=%0d unstable=%0d overlap=%0d read_b=%0d want %0d 0 0 %0d",
                     f, dropped, unstable, overlap, readb_count, exp_drop, count);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      frame_start = 1'b0;
      out_ready = 1'b1;
      clear_mon();
      test_reset();
      test_basic();
      test_stall();
      test_cull();
      test_clamp();
      test_empty();
      test_saturate();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
